keypad_scanner: RTL and testbench
=================================

Name: keypad_scanner

Overview:
- Scans a physical 4x4 CHIP-8 hex keypad matrix and debounces each key.
- Drives the `bit keyboard[15:0]` vector consumed by the CPU and the RNG; `keyboard[k]`=1 means key k is pressed.
- Implements the producer side of the FX0A "wait for key" handshake. It returns a key code on debounced release and holds it until the CPU accepts it.

Parameters:
- SCAN_DIV, 1000: clock cycles each row is driven before its columns are sampled (≥2).
- DEBOUNCE_SCANS, 4: consecutive disagreeing samples needed to flip a key's stable state (1..15).

Ports:
- clk_in  input  1  system clock
- rst_in  input  1  synchronous, active-high reset
- row_out  output  4  matrix row drive, active low; exactly one bit low
- col_in  input  4  matrix columns, active low (0 = key closed), already synchronised
- keyboard  output  bit[15:0] unpacked  debounced key state, index = CHIP-8 key value
- key_wait_in  input  1  CPU executing FX0A (level)
- key_valid_out  output  1  key_code_out holds a completed press/release
- key_ready_in  input  1  CPU accepts key_code_out
- key_code_out  output  4  released key value

Behaviour:
- Reset values: row_out=4'b1110; keyboard all 0; key_valid_out=0; key_code_out=0; divider, row index and all debounce counters 0; FSM IDLE.
- Matrix map, row r / col c → key:
  - r0: 1,2,3,C
  - r1: 4,5,6,D
  - r2: 7,8,9,E
  - r3: A,0,B,F
  - Example: r1c1 = key 5.
- Divider counts 0..SCAN_DIV-1. Row r is driven for the whole period.
- When the divider is at SCAN_DIV-1:
  - col_in is sampled for the current row;
  - the row index advances, wrapping 3→0;
  - row_out shows the new row on the next cycle.
- Debounce, per key, applied to the 4 keys of the sampled row:
  - sample == stable state → counter cleared;
  - otherwise counter increments; reaching DEBOUNCE_SCANS flips the stable state and clears the counter.
  - keyboard updates on the cycle after the sample.
  - Press latency is DEBOUNCE_SCANS samples of that row (spacing 4*SCAN_DIV cycles).
- Simultaneous presses are all reported independently in keyboard.
- Wait FSM:
  - IDLE: key_valid_out=0. Moves to ARMED when key_wait_in=1.
  - ARMED: on any debounced 0→1 edge of keyboard[k], latch k (lowest index if several edges in the same cycle) and move to HELD. Keys already held at arming do not qualify until released and re-pressed.
  - HELD: on the debounced 1→0 edge of the latched key, set key_code_out=k and key_valid_out=1, and move to PRESENT. Other keys are ignored.
  - PRESENT: key_valid_out stays 1 and key_code_out is stable. When key_valid_out && key_ready_in, key_valid_out=0 on the next cycle and the FSM returns to IDLE. key_ready_in outside PRESENT is ignored.
  - Cancel: key_wait_in=0 in ARMED or HELD → IDLE, nothing reported. key_wait_in is ignored in PRESENT.
- Reset asserted at any time, mid-scan or in any FSM state, restores every reset value on the next edge.

Optional Feature:
- KEYPAD_GHOST_REJECT_EN defined:
  - Samples are collected into a 16-bit raw frame.
  - Debounce is applied to all 16 keys at once when row 3's sample completes the frame; DEBOUNCE_SCANS then counts frames.
  - A frame is a ghost frame if any two rows both read low on at least two of the same columns. A ghost frame is discarded: no debounce counter or stable state changes.
- Undefined: per-row immediate debounce as above; no ghost check.

Test Plan:
- Reset check (SCAN_DIV=4, DEBOUNCE_SCANS=2): hold rst_in 3 cycles → row_out=1110, keyboard=0, key_valid_out=0. Free-run → row_out sequence 1110,1101,1011,0111 every 4 cycles.
- Single press: model closes r1c1 (col_in[1]=0 whenever row_out[1]=0) from reset release → keyboard[5]=1 on the cycle after the second row-1 sample, i.e. cycle 24. Release → keyboard[5]=0 after 2 further row-1 samples.
- Bounce: r2c3 toggles on alternate row-2 samples → keyboard[14] never changes.
- FX0A path: key_wait_in=1; press then release key A (r3c0), key_ready_in=0 → key_valid_out=1, key_code_out=A, held stable for 20 cycles. key_ready_in=1 for 1 cycle → valid=0 next cycle, FSM IDLE.
- Cancel and pre-held key: hold key 0 before key_wait_in=1 and release it → no report. Drop key_wait_in while in HELD → no report. Rearm and press/release key 3 → key_code_out=3.
- Ghost (macro defined): close r0c0, r0c1, r1c0, r1c1 → no keyboard change. Close only r0c0 → keyboard[1]=1 after 2 frames.

Source files
------------

// File: rtl/keypad_scanner.sv
// Scans a 4x4 CHIP-8 hex keypad, debounces every key and produces the FX0A key-wait handshake.
// Define KEYPAD_GHOST_REJECT_EN for whole-frame debounce with ghost-frame rejection.
module keypad_scanner #(
  parameter int unsigned SCAN_DIV       = 1000,
  parameter int unsigned DEBOUNCE_SCANS = 4
) (
  input  logic       clk_in,
  input  logic       rst_in,
  output logic [3:0] row_out,
  input  logic [3:0] col_in,
  output bit         keyboard [15:0],
  input  logic       key_wait_in,
  output logic       key_valid_out,
  input  logic       key_ready_in,
  output logic [3:0] key_code_out
);

  localparam int unsigned DivW = $clog2(SCAN_DIV);

  typedef enum logic [1:0] {StIdle, StArmed, StHeld, StPresent} state_e;

  // Matrix position (row, col) to CHIP-8 key value.
  function automatic logic [3:0] key_of(input logic [1:0] r, input logic [1:0] c);
    logic [3:0] k;
    case ({r, c})
      4'd0:    k = 4'h1;
      4'd1:    k = 4'h2;
      4'd2:    k = 4'h3;
      4'd3:    k = 4'hC;
      4'd4:    k = 4'h4;
      4'd5:    k = 4'h5;
      4'd6:    k = 4'h6;
      4'd7:    k = 4'hD;
      4'd8:    k = 4'h7;
      4'd9:    k = 4'h8;
      4'd10:   k = 4'h9;
      4'd11:   k = 4'hE;
      4'd12:   k = 4'hA;
      4'd13:   k = 4'h0;
      4'd14:   k = 4'hB;
      default: k = 4'hF;
    endcase
    return k;
  endfunction

  logic [DivW-1:0] div_q, div_d;
  logic [1:0]      row_q, row_d;
  logic            tick;
  logic [15:0]     samp, upd;
  logic [15:0]     stable_q, stable_d;
  logic [3:0]      cnt_q [16];
  logic [3:0]      cnt_d [16];
  logic [15:0]     rise, fall;
  state_e          state_q, state_d;
  logic [3:0]      key_q, key_d;
  logic [3:0]      code_q, code_d;

  assign tick = (div_q == DivW'(SCAN_DIV - 1));

  always_comb begin
    div_d = tick ? '0 : div_q + 1'b1;
    row_d = tick ? row_q + 2'd1 : row_q;
  end

  assign row_out = ~(4'b0001 << row_q);

`ifdef KEYPAD_GHOST_REJECT_EN
  logic [15:0] raw_q, raw_d;
  logic        ghost;

  // Two rows sharing two or more closed columns make the frame ambiguous.
  function automatic logic is_ghost(input logic [15:0] f);
    logic g;
    g = 1'b0;
    for (int i = 0; i < 4; i++) begin
      for (int j = i + 1; j < 4; j++) begin
        if ($countones(f[i*4 +: 4] & f[j*4 +: 4]) >= 2) g = 1'b1;
      end
    end
    return g;
  endfunction

  always_comb begin
    raw_d = raw_q;
    if (tick) raw_d[{row_q, 2'b00} +: 4] = ~col_in;
    ghost = is_ghost(raw_d);
    samp  = '0;
    for (int p = 0; p < 16; p++) begin
      samp[key_of(2'(p / 4), 2'(p % 4))] = raw_d[p];
    end
    upd = (tick && row_q == 2'd3 && !ghost) ? 16'hFFFF : 16'h0000;
  end
`else
  always_comb begin
    samp = '0;
    upd  = '0;
    for (int c = 0; c < 4; c++) begin
      samp[key_of(row_q, 2'(c))] = ~col_in[c];
      upd[key_of(row_q, 2'(c))]  = tick;
    end
  end
`endif

  always_comb begin
    stable_d = stable_q;
    for (int k = 0; k < 16; k++) begin
      cnt_d[k] = cnt_q[k];
      if (upd[k]) begin
        if (samp[k] == stable_q[k]) begin
          cnt_d[k] = '0;
        end else if (cnt_q[k] == 4'(DEBOUNCE_SCANS - 1)) begin
          stable_d[k] = ~stable_q[k];
          cnt_d[k]    = '0;
        end else begin
          cnt_d[k] = cnt_q[k] + 4'd1;
        end
      end
    end
    rise = stable_d & ~stable_q;
    fall = ~stable_d & stable_q;
  end

  always_comb begin
    state_d = state_q;
    key_d   = key_q;
    code_d  = code_q;
    unique case (state_q)
      StIdle: begin
        if (key_wait_in) state_d = StArmed;
      end
      StArmed: begin
        if (!key_wait_in) begin
          state_d = StIdle;
        end else if (|rise) begin
          state_d = StHeld;
          // Descending scan so the lowest rising key wins.
          for (int k = 15; k >= 0; k--) begin
            if (rise[k]) key_d = 4'(k);
          end
        end
      end
      StHeld: begin
        if (!key_wait_in) begin
          state_d = StIdle;
        end else if (fall[key_q]) begin
          code_d  = key_q;
          state_d = StPresent;
        end
      end
      StPresent: begin
        if (key_ready_in) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      div_q    <= '0;
      row_q    <= '0;
      stable_q <= '0;
      for (int k = 0; k < 16; k++) cnt_q[k] <= '0;
      state_q  <= StIdle;
      key_q    <= '0;
      code_q   <= '0;
`ifdef KEYPAD_GHOST_REJECT_EN
      raw_q    <= '0;
`endif
    end else begin
      div_q    <= div_d;
      row_q    <= row_d;
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
      state_q  <= state_d;
      key_q    <= key_d;
      code_q   <= code_d;
`ifdef KEYPAD_GHOST_REJECT_EN
      raw_q    <= raw_d;
`endif
    end
  end

  always_comb begin
    for (int k = 0; k < 16; k++) keyboard[k] = stable_q[k];
  end

  assign key_valid_out = (state_q == StPresent);
  assign key_code_out  = code_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner (SCAN_DIV=4, DEBOUNCE_SCANS=2) with a switch-matrix model.
module tb_keypad_scanner;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic [3:0]  row_out;
  logic [3:0]  col_in;
  bit          keyboard [15:0];
  logic        key_wait_in;
  logic        key_valid_out;
  logic        key_ready_in;
  logic [3:0]  key_code_out;

  logic [15:0] closed;  // matrix order: bit r*4+c
  logic [15:0] kb;
  int          cyc;
  int          n_pass;
  int          n_total;

  always #5 clk_in = ~clk_in;

  always_comb begin
    col_in = 4'hF;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        if (!row_out[r] && closed[r*4 + c]) col_in[c] = 1'b0;
      end
    end
    for (int i = 0; i < 16; i++) kb[i] = keyboard[i];
  end

  keypad_scanner #(
    .SCAN_DIV      (4),
    .DEBOUNCE_SCANS(2)
  ) dut (
    .clk_in       (clk_in),
    .rst_in       (rst_in),
    .row_out      (row_out),
    .col_in       (col_in),
    .keyboard     (keyboard),
    .key_wait_in  (key_wait_in),
    .key_valid_out(key_valid_out),
    .key_ready_in (key_ready_in),
    .key_code_out (key_code_out)
  );

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
  endtask

  // Advance to cycle n (counted from reset release), then step 1 time unit past the edge.
  task automatic go(input int n);
    while (cyc < n) begin
      @(posedge clk_in);
      cyc++;
    end
    #1;
  endtask

  initial begin
    closed       = '0;
    rst_in       = 1'b1;
    key_wait_in  = 1'b0;
    key_ready_in = 1'b0;
    cyc          = 0;
    n_pass       = 0;
    n_total      = 0;

    repeat (3) @(posedge clk_in);
    #1;
    check("reset_row", {12'h0, row_out}, 16'h000E);
    check("reset_kb", kb, 16'h0000);
    check("reset_valid", {15'h0, key_valid_out}, 16'h0000);
    check("reset_code", {12'h0, key_code_out}, 16'h0000);

`ifdef KEYPAD_GHOST_REJECT_EN
    closed = 16'h0033;  // r0c0 r0c1 r1c0 r1c1
`else
    closed = 16'h0020;  // r1c1 = key 5
`endif
    rst_in = 1'b0;

    go(3);  check("row_c3", {12'h0, row_out}, 16'h000E);
    go(4);  check("row_c4", {12'h0, row_out}, 16'h000D);
    go(8);  check("row_c8", {12'h0, row_out}, 16'h000B);
    go(12); check("row_c12", {12'h0, row_out}, 16'h0007);
    go(16); check("row_c16", {12'h0, row_out}, 16'h000E);

`ifdef KEYPAD_GHOST_REJECT_EN
    go(48); check("ghost_kb_48", kb, 16'h0000);
    go(80); check("ghost_kb_80", kb, 16'h0000);
    closed = 16'h0001;  // r0c0 = key 1 alone
    go(111); check("single_kb_111", kb, 16'h0000);
    go(112); check("single_kb_112", kb, 16'h0002);
`else
    // Single press of key 5
    go(23); check("press5_c23", kb, 16'h0000);
    go(24); check("press5_c24", kb, 16'h0020);
    closed = 16'h0000;
    go(55); check("rel5_c55", kb, 16'h0020);
    go(56); check("rel5_c56", kb, 16'h0000);

    // Key E bounces on alternate row-2 samples
    for (int i = 0; i < 6; i++) begin
      go(56 + 16 * i);
      closed[11] = ((i % 2) == 0);
      go(64 + 16 * i);
      check("bounce_e", kb, 16'h0000);
    end
    closed = 16'h0000;

    // FX0A: press and release key A
    go(160);
    key_wait_in = 1'b1;
    closed[12]  = 1'b1;
    go(191); check("a_press_c191", kb, 16'h0000);
    go(192); check("a_press_c192", kb, 16'h0400);
    check("a_held_valid", {15'h0, key_valid_out}, 16'h0000);
    closed[12] = 1'b0;
    go(223); check("a_rel_valid_c223", {15'h0, key_valid_out}, 16'h0000);
    go(224); check("a_valid_c224", {15'h0, key_valid_out}, 16'h0001);
    check("a_code_c224", {12'h0, key_code_out}, 16'h000A);
    go(230); key_wait_in = 1'b0;
    go(244); check("a_valid_c244", {15'h0, key_valid_out}, 16'h0001);
    check("a_code_c244", {12'h0, key_code_out}, 16'h000A);
    key_ready_in = 1'b1;
    go(245); key_ready_in = 1'b0;
    check("a_accept_c245", {15'h0, key_valid_out}, 16'h0000);
    go(250); check("a_idle_c250", {15'h0, key_valid_out}, 16'h0000);

    // Key 0 held before arming, then released: no report
    go(256); closed[13] = 1'b1;
    go(288); check("k0_press", kb, 16'h0001);
    go(290);
    key_wait_in = 1'b1;
    closed[13]  = 1'b0;
    go(320); check("k0_rel", kb, 16'h0000);
    go(330); check("k0_no_report", {15'h0, key_valid_out}, 16'h0000);

    // Key 3 pressed, wait cancelled while held
    closed[2] = 1'b1;
    go(356); check("k3_press", kb, 16'h0008);
    check("k3_held_valid", {15'h0, key_valid_out}, 16'h0000);
    go(360);
    key_wait_in = 1'b0;
    closed[2]   = 1'b0;
    go(388); check("k3_rel", kb, 16'h0000);
    go(392); check("k3_cancel", {15'h0, key_valid_out}, 16'h0000);

    // Rearm, press and release key 3
    key_wait_in = 1'b1;
    closed[2]   = 1'b1;
    go(420); check("k3b_press", kb, 16'h0008);
    closed[2] = 1'b0;
    go(451); check("k3b_valid_c451", {15'h0, key_valid_out}, 16'h0000);
    go(452); check("k3b_valid_c452", {15'h0, key_valid_out}, 16'h0001);
    check("k3b_code", {12'h0, key_code_out}, 16'h0003);
    key_ready_in = 1'b1;
    go(453); key_ready_in = 1'b0;
    check("k3b_accept", {15'h0, key_valid_out}, 16'h0000);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
